multicycle_control_fsm: RTL

Main control state machine for the multi-cycle CPU datapath. It decodes the 6-bit opcode latched in the instruction register and steps each instruction through fetch, decode, execute, memory and write-back. Each cycle it drives the select lines of the datapath's 2:1 and 4:1 multiplexers, plus the register, memory and PC write enables. It sits directly upstream of the datapath multiplexers, including the 6-bit field muxes.

---
 rtl/multicycle_control_fsm_pkg.sv | 71 +++++++
 rtl/ctrl_output_decode.sv | 64 ++++++
 rtl/multicycle_control_fsm.sv | 92 +++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, state
// encoding, datapath mux select encodings and the control vector bundle.
package cpu_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> control vector decoder. Only FETCH looks at
// mem_ready; DECODE looks at the opcode solely to flag illegal encodings.
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.illegal   = !op_legal(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle CPU main control: state register and next-state logic; the
// datapath control vector comes from ctrl_output_decode.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal,
  output logic [3:0]          state
);

  state_t st;
  ctrl_t  ctrl;
  logic   zero_unused;

  // zero is consumed by the datapath through pc_write_cond, not here.
  assign zero_unused = zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_IDLE;
    end else begin
      case (st)
        S_IDLE:   st <= S_FETCH;
        S_FETCH:  st <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: st <= S_MEMADR;
            OP_RTYPE:     st <= S_EXEC;
            OP_BEQ:       st <= S_BRANCH;
            OP_ADDI:      st <= S_ADDIEX;
            OP_J:         st <= S_JUMP;
            default:      st <= S_FETCH;
          endcase
        end
        S_MEMADR: st <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  st <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:  st <= S_FETCH;
        S_MEMWR:  st <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC:   st <= S_ALUWB;
        S_ALUWB:  st <= S_FETCH;
        S_ADDIEX: st <= S_ADDIWB;
        S_ADDIWB: st <= S_FETCH;
        S_BRANCH: st <= S_FETCH;
        S_JUMP:   st <= S_FETCH;
        default:  st <= S_IDLE;
      endcase
    end
  end

  ctrl_output_decode u_decode (
    .state     (st),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal       = ctrl.illegal;
  assign state         = st;

endmodule
